// File: rtl/alu_seq_pkg.sv
// Shared opcodes, sequencer state type and the divide-by-zero result for alu_op_sequencer.
package alu_seq_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  localparam logic [7:0] DBZ_RESULT = 8'hFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } seq_state_e;

endpackage

// File: rtl/alu_op_sequencer_alu.sv
// Combinational ALU: add, sub, mul (low bits), unsigned div; all modulo 2^DATA_W.
module alu
  import alu_seq_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] A,
  input  logic [DATA_W-1:0] B,
  input  logic [1:0]        ALU_Sel,
  output logic [DATA_W-1:0] ALU_Out
);

  always_comb begin
    ALU_Out = '0;
    case (ALU_Sel)
      OP_ADD:  ALU_Out = A + B;
      OP_SUB:  ALU_Out = A - B;
      OP_MUL:  ALU_Out = A * B;
      OP_DIV:  ALU_Out = (B == '0) ? '0 : A / B;
      default: ALU_Out = '0;
    endcase
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// Issue/capture sequencer around the combinational alu: one op in flight, valid/ready both sides.
// Optional accumulator operand source enabled by defining ALU_SEQ_ACCUM_EN.
//
// state | meaning
// IDLE  | ready for a new operation
// EXEC  | operands held on the ALU, settle counter running
// RESP  | result presented, waiting for out_ready
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int DATA_W        = 8,
  parameter int SETTLE_CYCLES = 1,
  parameter int CNT_W         = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  input  logic [1:0]        in_sel,
`ifdef ALU_SEQ_ACCUM_EN
  input  logic              in_use_acc,
`endif
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic [1:0]        out_sel,
  output logic              out_dbz,
  output logic              busy,
  output logic [CNT_W-1:0]  op_count
);

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

  seq_state_e        state;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic [1:0]        op_sel;
  logic [3:0]        settle_cnt;
  logic [DATA_W-1:0] alu_out;
  logic [DATA_W-1:0] a_src;

`ifdef ALU_SEQ_ACCUM_EN
  logic [DATA_W-1:0] acc;
  always_comb a_src = in_use_acc ? acc : in_a;
`else
  always_comb a_src = in_a;
`endif

  alu #(.DATA_W(DATA_W)) u_alu (
    .A       (op_a),
    .B       (op_b),
    .ALU_Sel (op_sel),
    .ALU_Out (alu_out)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      out_result <= '0;
      out_sel    <= '0;
      out_dbz    <= 1'b0;
      busy       <= 1'b0;
      op_count   <= '0;
      op_a       <= '0;
      op_b       <= '0;
      op_sel     <= '0;
      settle_cnt <= '0;
`ifdef ALU_SEQ_ACCUM_EN
      acc        <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            op_a       <= a_src;
            op_b       <= in_b;
            op_sel     <= in_sel;
            settle_cnt <= SETTLE_LOAD;
            in_ready   <= 1'b0;
            busy       <= 1'b1;
            state      <= EXEC;
          end
        end
        EXEC: begin
          if (settle_cnt != 4'd0) begin
            settle_cnt <= settle_cnt - 4'd1;
          end else begin
            // Divide-by-zero overrides whatever the ALU produces.
            if (op_sel == OP_DIV && op_b == '0) begin
              out_result <= DBZ_RESULT;
              out_dbz    <= 1'b1;
            end else begin
              out_result <= alu_out;
              out_dbz    <= 1'b0;
            end
            out_sel   <= op_sel;
            out_valid <= 1'b1;
            state     <= RESP;
          end
        end
        RESP: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            op_count  <= op_count + 1'b1;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
`ifdef ALU_SEQ_ACCUM_EN
            acc       <= out_result;
`endif
            state     <= IDLE;
          end
        end
        default: begin
          state    <= IDLE;
          in_ready <= 1'b1;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Scoreboard bench for alu_op_sequencer: directed ops, backpressure, reset mid-op, random ops.
module tb_alu_op_sequencer;

  localparam int SETTLE = 4;

  typedef struct packed {
    logic [7:0] result;
    logic [1:0] sel;
    logic       dbz;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_a = '0;
  logic [7:0]  in_b = '0;
  logic [1:0]  in_sel = '0;
  logic        in_use_acc = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [7:0]  out_result;
  logic [1:0]  out_sel;
  logic        out_dbz;
  logic        busy;
  logic [15:0] op_count;

  exp_t        sb_q[$];
  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;
  int          accept_cyc = 0;
  logic [15:0] exp_count = 0;
  logic [7:0]  acc_m = 0;
  bit          rand_ready = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu_op_sequencer #(.DATA_W(8), .SETTLE_CYCLES(SETTLE), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_sel(in_sel),
`ifdef ALU_SEQ_ACCUM_EN
    .in_use_acc(in_use_acc),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_sel(out_sel), .out_dbz(out_dbz), .busy(busy), .op_count(op_count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, req, cyc);
    end
  endtask

  // Reference model: arithmetic straight from the opcode definitions.
  function automatic exp_t model(input logic [7:0] a, input logic [7:0] b, input logic [1:0] s);
    exp_t e;
    int unsigned r;
    e.sel = s;
    e.dbz = 1'b0;
    case (s)
      2'd0: r = (int'(a) + int'(b)) % 256;
      2'd1: r = (int'(a) - int'(b) + 256) % 256;
      2'd2: r = (int'(a) * int'(b)) % 256;
      default: begin
        if (b == 0) begin r = 255; e.dbz = 1'b1; end
        else r = int'(a) / int'(b);
      end
    endcase
    e.result = 8'(r);
    return e;
  endfunction

  task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic [1:0] s, input bit ua);
    int n = 0;
    exp_t e;
    logic [7:0] ea;
    while (!in_ready && n < 300) begin @(posedge clk); #1; n++; end
    if (!in_ready) begin
      miscompares++;
      $display("FAIL issue_timeout: in_ready stayed 0 for %0d cycles", n);
      return;
    end
`ifdef ALU_SEQ_ACCUM_EN
    ea = ua ? acc_m : a;
`else
    ea = a;
`endif
    e = model(ea, b, s);
    acc_m = e.result;
    in_a = a; in_b = b; in_sel = s; in_use_acc = ua; in_valid = 1'b1;
    sb_q.push_back(e);
    vectors++;
    @(posedge clk); #1;
    accept_cyc = cyc;
    in_valid = 1'b0;
    in_a = $urandom; in_b = $urandom; in_sel = 2'($urandom);
    @(posedge clk); #1;
  endtask

  task automatic drain();
    int n = 0;
    while ((sb_q.size() != 0 || !in_ready) && n < 300) begin @(posedge clk); #1; n++; end
    if (sb_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain_timeout: %0d results outstanding, required 0", sb_q.size());
      sb_q.delete();
    end
  endtask

  // Monitor: handshakes, latency, hold stability, in_ready/busy, op_count.
  bit         hold_pending = 0;
  bit         prev_valid = 0;
  logic [7:0] h_res;
  logic [1:0] h_sel;
  logic       h_dbz;
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      hold_pending = 0;
      prev_valid = 0;
    end else begin
      check("in_ready_vs_busy", in_ready, !busy);
      check("op_count", op_count, exp_count);
      if (hold_pending) begin
        check("hold_valid", out_valid, 1'b1);
        check("hold_result", out_result, h_res);
        check("hold_sel", out_sel, h_sel);
        check("hold_dbz", out_dbz, h_dbz);
      end
      if (out_valid && !prev_valid) check("latency", cyc - accept_cyc, SETTLE);
      if (out_valid && in_ready) check("in_ready_in_resp", in_ready, 1'b0);
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          miscompares++;
          $display("FAIL spurious_out: result %0h with empty scoreboard", out_result);
        end else begin
          e = sb_q.pop_front();
          check("out_result", out_result, e.result);
          check("out_sel", out_sel, e.sel);
          check("out_dbz", out_dbz, e.dbz);
        end
        exp_count = exp_count + 1'b1;
      end
      hold_pending = out_valid && !out_ready;
      h_res = out_result; h_sel = out_sel; h_dbz = out_dbz;
      prev_valid = out_valid;
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      if (rand_ready) out_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #12;
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_op_count", op_count, 16'd0);
    check("rst_out_result", out_result, 8'h00);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // Directed arithmetic, including divide-by-zero and the op after it.
    issue(8'h0A, 8'h02, 2'b00, 0);
    issue(8'hF6, 8'h0A, 2'b01, 0);
    issue(8'h0F, 8'h03, 2'b10, 0);
    issue(8'h1E, 8'h04, 2'b11, 0);
    issue(8'h1E, 8'h00, 2'b11, 0);
    issue(8'h09, 8'h03, 2'b11, 0);
    drain();
    check("op_count_after_directed", op_count, 16'd6);

    // Backpressure: result held for 5 cycles while in_valid pulses are ignored.
    out_ready = 1'b0;
    issue(8'h0A, 8'h02, 2'b00, 0);
    for (int i = 0; i < SETTLE + 5; i++) begin
      in_valid = 1'(i % 2);
      in_a = 8'h55; in_b = 8'h11; in_sel = 2'b10;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check("bp_out_valid", out_valid, 1'b1);
    check("bp_out_result", out_result, 8'h0C);
    out_ready = 1'b1;
    drain();
    check("op_count_after_bp", op_count, 16'd7);

    // Reset two cycles into EXEC: op dropped, outputs back to reset values at once.
    issue(8'h33, 8'h11, 2'b00, 0);
    #1 rst = 1'b1;
    #1;
    sb_q.delete();
    exp_count = 0;
    acc_m = 0;
    check("midrst_out_valid", out_valid, 1'b0);
    check("midrst_in_ready", in_ready, 1'b1);
    check("midrst_busy", busy, 1'b0);
    check("midrst_op_count", op_count, 16'd0);
    check("midrst_out_result", out_result, 8'h00);
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < SETTLE + 3; i++) @(posedge clk);
    #1;

`ifdef ALU_SEQ_ACCUM_EN
    issue(8'h0A, 8'h02, 2'b00, 0);
    issue(8'hEE, 8'h05, 2'b00, 1);
    issue(8'hEE, 8'h02, 2'b10, 1);
    drain();
`endif

    // Random ops with random consumer backpressure.
    rand_ready = 1;
    for (int i = 0; i < 60; i++) begin
      logic [7:0] b;
      b = ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom);
      issue(8'($urandom), b, 2'($urandom), 1'($urandom_range(0, 1)));
    end
    drain();
    rand_ready = 0;
    out_ready = 1'b1;
    @(posedge clk); #1;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: bench did not complete");
    $fatal(1);
  end

endmodule
